alu_arbiter: RTL
================

# alu_arbiter

Shares the single 32-bit ALU between up to four requesters: the integer execute stage, branch-target/compare logic and address generation. It runs a three-state controller that accepts one operation at a time with round-robin fairness, drives the ALU from registered operands, and returns the result and zero flag to the requester that issued the operation. The ALU itself is instantiated beside this block and connects through the `alu_*` ports.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.
- `DATA_W`, default 32: operand and result width; fixed at 32 for the current ALU.
- `clk`  in  1: single clock; everything is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: request valid, one bit per requester.
- `req_ready`  out  NUM_REQ: request accepted; one-hot or zero.
- `req_a`, `req_b`  in  NUM_REQ*DATA_W: packed operands; requester i occupies bits [i*32 +: 32].
- `req_op`  in  NUM_REQ*4: packed alu_control codes.
- `rsp_valid`  out  NUM_REQ: response valid to the owning requester; one-hot or zero.
- `rsp_ready`  in  NUM_REQ: response consumed.
- `rsp_result`  out  DATA_W: result, shared by all requesters.
- `rsp_zero`  out  1: zero flag, shared by all requesters.
- `alu_a`, `alu_b`  out  DATA_W: registered operands to the ALU.
- `alu_control`  out  4: registered opcode to the ALU.
- `alu_result`  in  DATA_W: ALU result, combinational from `alu_*`.
- `alu_zero`  in  1: ALU zero flag.

## Operation
- **States:** IDLE, EXEC, RESP. An `owner` register (2 bits) and a round-robin pointer `rr_ptr` (2 bits) are also held.
- **IDLE**
  - Grant the first set `req_valid` bit scanning from `rr_ptr` upward, modulo NUM_REQ.
  - Assert `req_ready[grant]` combinationally in the same cycle. `req_ready` is 0 in every other state.
  - On the handshake: latch `req_a`, `req_b` and `req_op` of the granted requester into `alu_a`, `alu_b` and `alu_control`; set `owner` to the grant; go to EXEC.
- **EXEC:** the ALU evaluates. At the clock edge, capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`, then go to RESP.
- **RESP**
  - Hold `rsp_valid[owner]` high until `rsp_ready[owner]` is sampled high.
  - On that handshake: set `rr_ptr` to (owner+1) mod NUM_REQ and go to IDLE.
  - `rsp_ready` bits of non-owners are ignored.
- Opcodes pass through unchanged. There is no illegal-opcode check; an unsupported code yields whatever the ALU produces.
- `alu_*` outputs hold their last values outside EXEC.
- **Reset:** state IDLE, `rr_ptr` 0, `owner` 0. `req_ready`, `rsp_valid`, `rsp_result`, `rsp_zero`, `alu_a`, `alu_b` and `alu_control` are all 0.
- **Reset in EXEC or RESP:** the in-flight operation is discarded and no response is issued.
- A requester that drops `req_valid` before being granted is simply skipped.

## Timing
- **Latency:** request handshake in cycle T gives `rsp_valid` high from cycle T+2.
- **Throughput:** with `rsp_ready` tied high, at most one operation every 3 cycles.
- `req_ready` depends combinationally on `req_valid` and state. All other outputs are registered.
- **Simultaneous requests:** only one grant per IDLE cycle. After reset, requester 0 wins a tie; after that the last-served requester has lowest priority.
- **Stable response:** `rsp_result` and `rsp_zero` stay stable for the whole of RESP, however long backpressure lasts.

## Configuration
- Macro `ALU_ARB_PERF_EN`.
- **When defined:** adds output `perf_grant_cnt` (NUM_REQ*32, packed) and output `perf_stall_cnt` (32).
  - Grant counter i increments on each request handshake of requester i.
  - `perf_stall_cnt` increments on every cycle in which any `req_valid` is high but no handshake occurs.
  - Both counters wrap at 2^32 and reset to 0.
- **When undefined:** the ports and counters do not exist, and the remaining behaviour is identical.

## Structure
- Package `alu_arb_pkg` holds:
  - the state enum (IDLE, EXEC, RESP);
  - the opcode constants: ADD 4'b0000, SUB 4'b0001, AND 4'b0010, SLL 4'b0101, SLT 4'b1000;
  - `MAX_REQ` = 4.
- Sub-module `rr_arbiter`: combinational round-robin pick from (`req_valid`, `rr_ptr`), producing a one-hot `grant` and an `any` flag.

## Test plan
- **Single ADD:** `req_valid[0]` with a=0x0000000A, b=0x00000005, op 0000 gives `req_ready[0]` at T and `rsp_valid[0]` at T+2 with `rsp_result` 0x0000000F and `rsp_zero` 0.
- **Tie after reset:** req0 SUB 0x0F−0x03 and req1 AND 0xF0F0F0F0&0xFF00FF00 both valid. req0 is served first with 0x0000000C; req1 is granted in the next IDLE with 0xF000F000. In the next tie, req0 wins again, because `rr_ptr` points to 0 after req1 is served.
- **Backpressure:** SLT 0xFFFFFFFF<0x00000001 with `rsp_ready` low for 5 cycles. `rsp_valid` stays held with result 0x00000001 stable, and `req_ready` stays 0 while req1 is pending.
- **Zero flag:** SUB 5−5 gives `rsp_result` 0 and `rsp_zero` 1.
- **Reset mid-operation:** `rst` in EXEC gives all outputs 0 on the next cycle, no `rsp_valid`, and after release the first tie goes to req0.
- **Counters (`ALU_ARB_PERF_EN`):** 3 grants to req0, 2 to req1, with req1 waiting 4 cycles, gives `perf_grant_cnt` {2,3} and a `perf_stall_cnt` that matches the cycle-accurate model.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice: controller state
// encoding, the ALU opcode values and the supported requester count.
package alu_arb_pkg;

    localparam int MAX_REQ = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0101;
    localparam logic [3:0] OP_SLT = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick. Scans req_valid starting at
// rr_ptr and wrapping modulo NUM_REQ; returns a one-hot grant and an any flag.
module rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [1:0]         rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    // First valid requester at or after rr_ptr wins.
    always_comb begin
        // NOTE: every output gets a default before the loops so no path can infer a latch.
        grant = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!any && req_valid[i] && (i == (int'(rr_ptr) + k) % NUM_REQ)) begin
                    grant[i] = 1'b1;
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between NUM_REQ (2..4) requesters.
// Three-state controller (IDLE -> EXEC -> RESP) with round-robin fairness;
// ALU operands/opcode and the response are all registered.
// Optional feature macro: ALU_ARB_PERF_EN adds grant and stall counters.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    input  logic [NUM_REQ*4-1:0]        req_op,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [DATA_W-1:0]           rsp_result,
    output logic                        rsp_zero,
    output logic [DATA_W-1:0]           alu_a,
    output logic [DATA_W-1:0]           alu_b,
    output logic [3:0]                  alu_control,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic                        alu_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]       perf_grant_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    localparam logic [1:0] LAST_REQ = 2'(NUM_REQ - 1);

    state_t               state;
    logic [1:0]           owner;
    logic [1:0]           rr_ptr;
    logic [NUM_REQ-1:0]   grant;
    logic                 any;
    logic [1:0]           grant_idx;
    logic [DATA_W-1:0]    sel_a;
    logic [DATA_W-1:0]    sel_b;
    logic [3:0]           sel_op;
    logic                 rsp_ack;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .any       (any)
    );

    // The grant is only offered while the controller is waiting for work.
    assign req_ready = (state == IDLE) ? grant : '0;

    // rsp_valid is one-hot on the owner, so any overlap is the owner's accept.
    assign rsp_ack = |(rsp_valid & rsp_ready);

    // Select the granted requester's operands, opcode and index.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a     = req_a[i*DATA_W +: DATA_W];
                sel_b     = req_b[i*DATA_W +: DATA_W];
                sel_op    = req_op[i*4 +: 4];
                grant_idx = 2'(i);
            end
        end
    end

    // Controller: accept one operation, let the ALU settle, hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= '0;
            rr_ptr      <= '0;
            rsp_valid   <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            alu_a       <= '0;
            alu_b       <= '0;
            alu_control <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (any) begin
                        alu_a       <= sel_a;
                        alu_b       <= sel_b;
                        alu_control <= sel_op;
                        owner       <= grant_idx;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        rsp_valid[i] <= (owner == 2'(i));
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ack) begin
                        rsp_valid <= '0;
                        rr_ptr    <= (owner == LAST_REQ) ? 2'd0 : owner + 2'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    // Per-requester grant counts and cycles where work waited without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_grant_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) begin
                    perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
                end
            end
            if ((|req_valid) && !(|req_ready)) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
